mux_rr_scheduler: RTL and testbench

//  Round-robin scheduler sharing one DATA_W-bit output channel among 8 requesters.

---
 rtl/mux_sched_pkg.sv | 12 +
 rtl/mux_rr_scheduler_rr_pick.sv | 30 +++
 rtl/mux_rr_scheduler.sv | 90 +++++++++
 tb/tb_mux_rr_scheduler.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_sched_pkg.sv
// Shared constants and FSM state encoding for the 8-way round-robin output scheduler.
package mux_sched_pkg;
   localparam int DATA_W = 256;
   localparam int N_REQ  = 8;
   localparam int SEL_W  = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      LOCK = 2'd2
   } state_t;
endpackage

// File: rtl/mux_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: rotate requests so ptr sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick
   import mux_sched_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] gnt_idx,
   output logic             any
);

   logic [N_REQ-1:0] rot;
   logic [SEL_W-1:0] off;

   // Index arithmetic is 3 bits wide, so ptr+k wraps modulo 8 for free.
   for (genvar k = 0; k < N_REQ; k++) begin : g_rot
      assign rot[k] = req[SEL_W'(k) + ptr];
   end

   always_comb begin
      off = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (rot[k]) off = SEL_W'(k);
      end
   end

   assign gnt_idx = off + ptr;
   assign any     = |req;

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one registered valid/ready channel among 8 requesters.
// Optional macro RR_LOCK_EN holds the grant on one requester until its i_last beat.
module mux_rr_scheduler
   import mux_sched_pkg::*;
(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic [N_REQ-1:0]        i_valid,
   input  logic [N_REQ*DATA_W-1:0] i_data,
   output logic [N_REQ-1:0]        o_ready,
   output logic                    o_valid,
   output logic [DATA_W-1:0]       o_data,
   output logic [SEL_W-1:0]        o_sel,
   input  logic                    i_ready,
   input  logic [N_REQ-1:0]        i_last
);

   state_t                        state;
   logic [SEL_W-1:0]              rr_ptr;
   logic [N_REQ-1:0]              elig;
   logic [SEL_W-1:0]              gnt_idx;
   logic                          any;
   logic                          slot_free;
   logic                          accept;
   logic [N_REQ-1:0][DATA_W-1:0]  lanes;
   logic [DATA_W-1:0]             pay;

`ifdef RR_LOCK_EN
   logic [SEL_W-1:0]              lock_idx;

   // While locked only the owning requester may win; others wait even if it idles.
   assign elig = (state == LOCK) ? (i_valid & (N_REQ'(1) << lock_idx)) : i_valid;
`else
   logic                          unused_last;

   assign elig        = i_valid;
   assign unused_last = ^i_last;
`endif

   rr_pick u_pick (
      .req     (elig),
      .ptr     (rr_ptr),
      .gnt_idx (gnt_idx),
      .any     (any)
   );

   assign lanes     = i_data;
   assign pay       = lanes[gnt_idx];
   assign slot_free = !o_valid || i_ready;
   assign accept    = !i_rst && slot_free && any;

   always_comb begin
      o_ready = '0;
      if (accept) o_ready[gnt_idx] = 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         o_valid <= 1'b0;
         o_data  <= '0;
         o_sel   <= '0;
`ifdef RR_LOCK_EN
         lock_idx <= '0;
`endif
      end else if (accept) begin
         o_valid <= 1'b1;
         o_data  <= pay;
         o_sel   <= gnt_idx;
`ifdef RR_LOCK_EN
         if (i_last[gnt_idx]) begin
            rr_ptr <= gnt_idx + 1'b1;
            state  <= BUSY;
         end else begin
            lock_idx <= gnt_idx;
            state    <= LOCK;
         end
`else
         rr_ptr <= gnt_idx + 1'b1;
         state  <= BUSY;
`endif
      end else if (slot_free) begin
         // Drain: payload and select keep their last value for debug visibility.
         o_valid <= 1'b0;
         if (state != LOCK) state <= IDLE;
      end
   end

endmodule

// File: tb/tb_mux_rr_scheduler.sv
// Scoreboard bench for mux_rr_scheduler; expected beats are queued at accept time
// from a behavioural arbiter model and popped when the output register updates.
module tb_mux_rr_scheduler;

   logic               i_clk;
   logic               i_rst;
   logic [7:0]         i_valid;
   logic [2047:0]      i_data;
   logic [7:0]         o_ready;
   logic               o_valid;
   logic [255:0]       o_data;
   logic [2:0]         o_sel;
   logic               i_ready;
   logic [7:0]         i_last;

`ifdef RR_LOCK_EN
   localparam bit LOCK_MODE = 1'b1;
`else
   localparam bit LOCK_MODE = 1'b0;
`endif

   mux_rr_scheduler dut (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (i_valid),
      .i_data  (i_data),
      .o_ready (o_ready),
      .o_valid (o_valid),
      .o_data  (o_data),
      .o_sel   (o_sel),
      .i_ready (i_ready),
      .i_last  (i_last)
   );

   always #5 i_clk = ~i_clk;

   int                 n_tests = 0;
   int                 n_fail  = 0;
   int                 seq     = 1;
   logic [7:0][255:0]  dat;
   logic [258:0]       sb[$];

   logic [2:0]         m_ptr;
   logic               m_lock;
   logic [2:0]         m_lidx;
   logic               m_ovalid;
   logic [2:0]         m_osel;
   logic [255:0]       m_odata;

   logic [7:0]         obs_rdy;
   logic [7:0]         exp_rdy;
   logic               exp_v;
   logic [2:0]         exp_sel;
   logic [255:0]       exp_data;

   function automatic logic [255:0] mk(input int k, input int s);
      logic [7:0] kb;
      kb = 8'(k);
      return {8{s[23:0], kb}};
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_lock = 0; m_lidx = 0;
      m_ovalid = 0; m_osel = 0; m_odata = '0;
      sb.delete();
   endtask

   task automatic fill_data();
      for (int k = 0; k < 8; k++) begin
         dat[k] = mk(k, seq);
         seq++;
      end
   endtask

   task automatic apply_reset();
      @(negedge i_clk);
      i_valid = 0; i_ready = 0; i_last = 0;
      i_rst = 1;
      model_reset();
      @(negedge i_clk);
      i_rst = 0;
      @(posedge i_clk); #1;
   endtask

   // One clock: drive, predict the winner, queue the expected beat, then settle outputs.
   task automatic step(input logic [7:0] v, input logic rdy, input logic [7:0] last);
      logic       free, acc;
      logic [2:0] w, idx;
      logic [7:0] elig;
      i_valid = v; i_ready = rdy; i_last = last; i_data = dat;
      @(negedge i_clk);
      free = !m_ovalid || rdy;
      elig = m_lock ? (v & (8'd1 << m_lidx)) : v;
      acc = 0; w = 0;
      if (free) begin
         for (int k = 0; k < 8; k++) begin
            idx = m_ptr + 3'(k);
            if (!acc && elig[idx]) begin acc = 1; w = idx; end
         end
      end
      exp_rdy = acc ? (8'd1 << w) : 8'd0;
      obs_rdy = o_ready;
      if (acc) begin
         sb.push_back({w, dat[w]});
         if (LOCK_MODE && !last[w]) begin m_lock = 1; m_lidx = w; end
         else begin m_lock = 0; m_ptr = w + 3'd1; end
      end
      @(posedge i_clk); #1;
      if (acc) begin
         {m_osel, m_odata} = sb.pop_front();
         m_ovalid = 1;
         dat[w] = mk(w, seq);
         seq++;
      end else if (free) begin
         m_ovalid = 0;
      end
      exp_v = m_ovalid; exp_sel = m_osel; exp_data = m_odata;
   endtask

   task automatic test_reset();
      #12;
      n_tests++;
      if (o_valid !== 1'b0 || o_sel !== 3'd0 || o_data !== '0 || o_ready !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_init: v=%b sel=%0d rdy=%h want 0/0/00", o_valid, o_sel, o_ready);
      end
      @(negedge i_clk); i_rst = 0; model_reset();
      @(posedge i_clk); #1;
      fill_data();
      for (int i = 0; i < 3; i++) step(8'hFF, 1'b1, 8'hFF);
      n_tests++;
      if (o_valid !== 1'b1 || o_data === '0) begin
         n_fail++;
         $display("FAIL reset_prerun: v=%b want 1 with nonzero data", o_valid);
      end
      #2 i_rst = 1;
      #1;
      n_tests++;
      if (o_valid !== 1'b0 || o_sel !== 3'd0 || o_data !== '0 || o_ready !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_async: v=%b sel=%0d rdy=%h data0=%b want 0/0/00/1",
                  o_valid, o_sel, o_ready, o_data === '0);
      end
      model_reset();
      @(negedge i_clk); i_rst = 0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_round_robin();
      int cnt[8];
      apply_reset();
      for (int k = 0; k < 8; k++) begin dat[k] = 256'(k); cnt[k] = 0; end
      for (int i = 0; i < 9; i++) begin
         step(8'hFF, 1'b1, 8'hFF);
         if (i < 8) for (int k = 0; k < 8; k++) if (obs_rdy[k]) cnt[k]++;
         n_tests++;
         if (obs_rdy !== exp_rdy || obs_rdy !== (8'd1 << (i % 8)) || o_valid !== exp_v ||
             o_sel !== 3'(i % 8) || o_sel !== exp_sel || o_data !== exp_data) begin
            n_fail++;
            $display("FAIL rr_cycle%0d: rdy=%h sel=%0d v=%b want rdy=%h sel=%0d v=1",
                     i, obs_rdy, o_sel, o_valid, exp_rdy, i % 8);
         end
      end
      for (int k = 0; k < 8; k++) begin
         n_tests++;
         if (cnt[k] != 1) begin
            n_fail++;
            $display("FAIL rr_pulses req%0d: got %0d want 1", k, cnt[k]);
         end
      end
   endtask

   task automatic test_skip_wrap();
      int want[3];
      want = '{0, 2, 0};
      apply_reset();
      fill_data();
      step(8'h20, 1'b1, 8'hFF);
      for (int i = 0; i < 3; i++) begin
         step(8'h05, 1'b1, 8'hFF);
         n_tests++;
         if (o_sel !== 3'(want[i]) || o_sel !== exp_sel || obs_rdy !== exp_rdy ||
             o_data !== exp_data || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL skip_wrap%0d: sel=%0d rdy=%h want sel=%0d rdy=%h",
                     i, o_sel, obs_rdy, want[i], exp_rdy);
         end
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] held;
      apply_reset();
      fill_data();
      step(8'h08, 1'b0, 8'hFF);
      held = exp_data;
      for (int i = 0; i < 5; i++) begin
         step(8'h08, 1'b0, 8'hFF);
         n_tests++;
         if (obs_rdy !== 8'd0 || o_valid !== 1'b1 || o_sel !== 3'd3 || o_data !== held) begin
            n_fail++;
            $display("FAIL stall%0d: rdy=%h v=%b sel=%0d stable=%b want 00/1/3/1",
                     i, obs_rdy, o_valid, o_sel, o_data === held);
         end
      end
      step(8'h08, 1'b1, 8'hFF);
      n_tests++;
      if (obs_rdy !== 8'h08 || o_valid !== 1'b1 || o_sel !== 3'd3 || o_data !== exp_data ||
          o_data === held) begin
         n_fail++;
         $display("FAIL stall_release: rdy=%h sel=%0d want rdy=08 sel=3 new data", obs_rdy, o_sel);
      end
   endtask

   task automatic test_drain();
      logic [255:0] a5;
      a5 = {32{8'hA5}};
      apply_reset();
      fill_data();
      dat[5] = a5;
      step(8'h20, 1'b1, 8'hFF);
      n_tests++;
      if (o_valid !== 1'b1 || o_sel !== 3'd5 || o_data !== a5 || obs_rdy !== 8'h20) begin
         n_fail++;
         $display("FAIL drain_beat: v=%b sel=%0d rdy=%h want 1/5/20", o_valid, o_sel, obs_rdy);
      end
      step(8'h00, 1'b1, 8'h00);
      n_tests++;
      if (o_valid !== 1'b0 || o_sel !== 3'd5 || o_data !== a5 || obs_rdy !== 8'd0 ||
          o_valid !== exp_v) begin
         n_fail++;
         $display("FAIL drain_drop: v=%b sel=%0d a5=%b want 0/5/1", o_valid, o_sel, o_data === a5);
      end
   endtask

   task automatic test_lock();
      int want[5];
      int cnt2;
      logic [7:0] v, last;
      if (LOCK_MODE) want = '{2, 2, 2, 4, 4};
      else           want = '{2, 4, 2, 4, 2};
      apply_reset();
      fill_data();
      cnt2 = 0;
      for (int i = 0; i < 5; i++) begin
         v    = 8'h10 | ((cnt2 < 3) ? 8'h04 : 8'h00);
         last = 8'h10 | ((cnt2 == 2) ? 8'h04 : 8'h00);
         step(v, 1'b1, last);
         if (obs_rdy[2]) cnt2++;
         n_tests++;
         if (o_sel !== 3'(want[i]) || o_sel !== exp_sel || obs_rdy !== exp_rdy ||
             o_data !== exp_data || o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_beat%0d: sel=%0d rdy=%h want sel=%0d rdy=%h",
                     i, o_sel, obs_rdy, want[i], exp_rdy);
         end
      end
   endtask

   initial begin
      i_clk = 0; i_rst = 1; i_valid = 8'hFF; i_ready = 1; i_last = 0; i_data = '0;
      dat = '0;
      model_reset();
      test_reset();
      test_round_robin();
      test_skip_wrap();
      test_backpressure();
      test_drain();
      test_lock();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation bound reached");
      $fatal(1, "timeout");
   end

endmodule
